spi_slave_shift: RTL and testbench
==================================

Name: spi_slave_shift

Overview:
SPI responder (slave) endpoint, the far end of our master shift engine: shifts an outgoing word onto MISO and assembles the incoming MOSI word, LSB first, SPI mode 0.
Fully synchronous to the system clock: SCLK, CS_N and MOSI are oversampled through synchronizers, and no logic is clocked by SCLK.
Frame length is selected by SPI_DATA_LEN with the same encoding as the master.
Sits between the SPI pins and a register-mapped peripheral via valid/ready TX and pulse RX interfaces.

Parameters:
DATA_WIDTH, 32, word width; only 32 supported (length encoding assumes it).
SYNC_STAGES, 2, flip-flop stages per synchronized input (≥2).

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-low reset: sampled on posedge clk, active when 0.
SCLK  input  1  SPI serial clock from master (asynchronous).
CS_N  input  1  chip select, active low (asynchronous).
MOSI  input  1  serial data from master.
MISO  output  1  serial data to master.
SPI_DATA_LEN  input  2  frame length: 00=8, 01=16, 10=24, 11=32 bits.
tx_data  input  DATA_WIDTH  next word to transmit.
tx_valid  input  1  tx_data valid.
tx_ready  output  1  TX holding register empty.
rx_data  output  DATA_WIDTH  last received word, right-aligned, upper bits zero.
rx_valid  output  1  one-cycle pulse: rx_data updated.
tx_underrun  output  1  one-cycle pulse: frame started with empty TX buffer.
frame_err  output  1  one-cycle pulse: CS_N deasserted mid-frame.
busy  output  1  high while state is SHIFT or HOLD.

Behaviour:
- Reset (rst==0 at posedge clk):
  - state IDLE; MISO=0; rx_data=0; rx_valid=0; tx_underrun=0; frame_err=0; busy=0; tx_ready=1.
  - bit counter 0; TX buffer empty; synchronizer flops set to SCLK=0, CS_N=1, MOSI=0.
  - Reset mid-frame aborts silently, with no frame_err.
- Synchronization: SCLK, CS_N and MOSI pass through identical SYNC_STAGES chains so relative timing is preserved. Edge detect on the last stage plus one delay flop.
- Timing constraint: SCLK high/low phases ≥3 clk; first SCLK rise ≥4 clk after CS_N fall.
- TX buffer handshake:
  - tx_ready = buffer empty. tx_valid && tx_ready at posedge stores tx_data; buffer becomes full.
  - tx_valid with tx_ready=0 is ignored; the holder keeps tx_valid asserted.
- IDLE, on CS_N fall (synchronized):
  - latch len from SPI_DATA_LEN; later changes are ignored until the next frame.
  - tx_shift <= buffer if full, else 0; buffer emptied (tx_ready=1 next cycle).
  - if the buffer was empty, pulse tx_underrun.
  - MISO <= bit0 of the loaded value; counter=0; go to SHIFT.
  - A word accepted in the same cycle as the CS_N fall stays in the buffer for the next frame.
- SHIFT:
  - SCLK rise: rx_shift <= rx_shift>>1 with MOSI written at bit len-1; counter+1.
  - SCLK fall with counter<len: tx_shift>>=1; MISO <= new bit0.
  - After the len-th rise: rx_data <= assembled word (bits ≥len zero); rx_valid=1 for exactly one cycle; go to HOLD.
- HOLD: MISO=0; further SCLK edges are ignored; CS_N rise goes to IDLE.
- CS_N rise in SHIFT (counter<len): pulse frame_err; no rx_valid; rx_data unchanged; MISO=0; go to IDLE. The loaded TX word is discarded.
- IDLE: MISO=0; busy=0.
- Simultaneous CS_N rise and final SCLK rise in the same cycle: the frame completes (rx_valid), then IDLE; no frame_err.
- MISO is a plain driven output; tristate is handled at the top level.

Decomposition:
- Package spi_pkg:
  - SPI_DATA_LEN encodings (SPI_LEN_8=2'b00, SPI_LEN_16=2'b01, SPI_LEN_24=2'b10, SPI_LEN_32=2'b11).
  - state enum {IDLE, SHIFT, HOLD}.
  - function spi_len_decode(2-bit) → 6-bit bit count.
  - Shared with the master.
- Sub-module sync_edge: SYNC_STAGES synchronizer with rise/fall outputs. Three instances; the MOSI instance uses only its level output.

Test Plan:
- SPI_DATA_LEN=00, tx word 0x000000A5, master sends 0x3C LSB first → MISO bits 1,0,1,0,0,1,0,1; rx_data=0x0000003C; one rx_valid pulse; busy low after CS_N rise.
- SPI_DATA_LEN=11, tx 0xDEADBEEF, master sends 0x12345678 → MISO carries 0xDEADBEEF LSB first; rx_data=0x12345678.
- No tx word loaded, 16-bit frame → tx_underrun pulse at CS_N fall; MISO all 0; rx still captured.
- CS_N raised after 5 of 8 bits → frame_err pulse; no rx_valid; rx_data holds previous value; next 8-bit frame is received correctly.
- Buffer 0x11 is loaded; 0x22 is offered in the CS_N-fall cycle, then two 8-bit frames run → MISO frames are 0x11 then 0x22; tx_ready low between them.
- rst=0 asserted mid-frame for one clk → all outputs at reset values next cycle; no frame_err; the remaining SCLK edges are ignored until the next CS_N fall.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Frame-length encodings, FSM states and length decode shared
//               by the SPI master and responder shift engines.
// Revision    : 1.0
// ============================================================================
package spi_pkg;

    localparam logic [1:0] SPI_LEN_8  = 2'b00;
    localparam logic [1:0] SPI_LEN_16 = 2'b01;
    localparam logic [1:0] SPI_LEN_24 = 2'b10;
    localparam logic [1:0] SPI_LEN_32 = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } spi_state_t;

    // Bit count is (code + 1) * 8.
    function automatic logic [5:0] spi_len_decode(input logic [1:0] code);
        return {({1'b0, code} + 3'd1), 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_shift_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Multi-stage input synchronizer with rise/fall edge detect.
// Revision    : 1.0
// ============================================================================
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_dly  <= RST_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_dly  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_dly;
    assign o_fall  = ~o_level & r_dly;

endmodule
`default_nettype wire

// File: rtl/spi_slave_shift.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_shift
// Description : Oversampled SPI mode-0 responder, LSB first, 8/16/24/32-bit.
// Revision    : 1.0
// ============================================================================
module spi_slave_shift
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCLK,
    input  logic                  CS_N,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [1:0]            SPI_DATA_LEN,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_err,
    output logic                  busy
);

    localparam logic [7:0] c_SETTLE = 8'(SYNC_STAGES);

    spi_state_t            r_state, w_state_next;
    logic [DATA_WIDTH-1:0] r_tx_buf, r_tx_shift, r_rx_shift, r_rx_data, w_rx_next;
    logic                  r_tx_full, r_rx_valid, r_tx_underrun, r_frame_err;
    logic [5:0]            r_len, r_cnt;
    logic [4:0]            w_pos;
    logic [7:0]            r_settle;
    logic                  r_armed, w_settled, w_last;
    logic                  w_load, w_rx_step, w_tx_step, w_done, w_abort;
    logic                  w_sclk_rise, w_sclk_fall, w_sclk_level_unused;
    logic                  w_cs_level, w_cs_rise, w_cs_fall;
    logic                  w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;
    logic                  w_rx_lsb_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_async(SCLK),
        .o_level(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .i_async(CS_N),
        .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .i_async(MOSI),
        .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
    );

    // After reset the CS_N chain holds a forced 1; a frame may only start once
    // the real pin has been seen high, so a reset mid-frame cannot re-enter it.
    assign w_settled = (r_settle == c_SETTLE);

    assign w_last          = ((r_cnt + 6'd1) == r_len);
    assign w_pos           = r_len[4:0] - 5'd1;
    assign w_rx_next       = {1'b0, r_rx_shift[DATA_WIDTH-1:1]}
                           | ({{(DATA_WIDTH-1){1'b0}}, w_mosi} << w_pos);
    assign w_rx_lsb_unused = r_rx_shift[0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_rx_step    = 1'b0;
        w_tx_step    = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall && r_armed) begin
                    w_load       = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                // A final rise coinciding with CS_N rise still completes.
                if (w_sclk_rise && w_last) begin
                    w_done       = 1'b1;
                    w_state_next = w_cs_rise ? IDLE : HOLD;
                end else if (w_cs_rise) begin
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_rx_step = w_sclk_rise;
                    w_tx_step = w_sclk_fall;
                end
            end
            HOLD: begin
                if (w_cs_rise) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_settle      <= '0;
            r_armed       <= 1'b0;
            r_tx_buf      <= '0;
            r_tx_full     <= 1'b0;
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            r_rx_data     <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;
            if (!w_settled) begin
                r_settle <= r_settle + 8'd1;
            end
            if (w_settled && w_cs_level) begin
                r_armed <= 1'b1;
            end
            if (tx_valid && !r_tx_full) begin
                r_tx_buf  <= tx_data;
                r_tx_full <= 1'b1;
            end
            if (w_load) begin
                r_len      <= spi_len_decode(SPI_DATA_LEN);
                r_cnt      <= '0;
                r_rx_shift <= '0;
                if (r_tx_full) begin
                    r_tx_shift <= r_tx_buf;
                    r_tx_full  <= 1'b0;
                end else begin
                    r_tx_shift    <= '0;
                    r_tx_underrun <= 1'b1;
                end
            end
            if (w_rx_step) begin
                r_rx_shift <= w_rx_next;
                r_cnt      <= r_cnt + 6'd1;
            end
            if (w_tx_step) begin
                r_tx_shift <= {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
            end
            if (w_done) begin
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
            end
            if (w_abort) begin
                r_frame_err <= 1'b1;
                r_tx_shift  <= '0;
            end
        end
    end

    assign MISO        = (r_state == SHIFT) & r_tx_shift[0];
    assign tx_ready    = ~r_tx_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_tx_underrun;
    assign frame_err   = r_frame_err;
    assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_shift.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_shift
// Description : Directed bench for spi_slave_shift with a word-level model.
// Revision    : 1.0
// ============================================================================
module tb_spi_slave_shift;

    localparam int PH = 6;

    logic        clk = 1'b0;
    logic        rst, SCLK, CS_N, MOSI, tx_valid;
    logic [1:0]  SPI_DATA_LEN;
    logic [31:0] tx_data;
    logic        MISO, tx_ready, rx_valid, tx_underrun, frame_err, busy;
    logic [31:0] rx_data;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_rxv   = 0;
    int          n_und   = 0;
    int          n_fe    = 0;
    logic [31:0] model_rx = '0;
    logic [31:0] exp_q[$];

    spi_slave_shift #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .CS_N(CS_N), .MOSI(MOSI), .MISO(MISO),
        .SPI_DATA_LEN(SPI_DATA_LEN), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] len_mask(input int n);
        logic [31:0] one;
        one = 32'h1;
        return (n >= 32) ? 32'hFFFF_FFFF : ((one << n) - 32'h1);
    endfunction

    // One clock: model update/compare after the edge, holder drops tx_valid once taken.
    task automatic tick();
        logic acc, rn;
        acc = tx_valid && tx_ready && rst;
        rn  = rst;
        @(posedge clk);
        #1;
        if (!rn) begin
            model_rx = '0;
        end else begin
            if (rx_valid) begin
                n_rxv++;
                if (exp_q.size() == 0) begin
                    chk("rx_valid_unexpected", 32'(rx_valid), 32'h0);
                end else begin
                    model_rx = exp_q.pop_front();
                end
            end
            if (tx_underrun) n_und++;
            if (frame_err)   n_fe++;
            chk("rx_data_model", rx_data, model_rx);
        end
        @(negedge clk);
        if (acc) tx_valid = 1'b0;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_miso"},     32'(MISO),        32'h0);
        chk({nm, "_rx_data"},  rx_data,          32'h0);
        chk({nm, "_rx_valid"}, 32'(rx_valid),    32'h0);
        chk({nm, "_underrun"}, 32'(tx_underrun), 32'h0);
        chk({nm, "_ferr"},     32'(frame_err),   32'h0);
        chk({nm, "_busy"},     32'(busy),        32'h0);
        chk({nm, "_tx_ready"}, 32'(tx_ready),    32'h1);
    endtask

    task automatic push(input logic [31:0] d);
        int k;
        tx_data  = d;
        tx_valid = 1'b1;
        k = 0;
        while (tx_valid && k < 50) begin
            tick();
            k++;
        end
        if (tx_valid) begin
            chk("push_timeout", 32'(tx_valid), 32'h0);
            tx_valid = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [1:0] lc, input logic [31:0] mo, input int stop_at,
                             input int rst_at, output logic [31:0] mi);
        int n;
        n  = 8 * (int'(lc) + 1);
        mi = '0;
        if (stop_at >= n && rst_at >= n) exp_q.push_back(mo & len_mask(n));
        SPI_DATA_LEN = lc;
        CS_N = 1'b0;
        MOSI = mo[0];
        repeat (PH) tick();
        for (int i = 0; i < n && i < stop_at; i++) begin
            if (i == rst_at) begin
                rst = 1'b0;
                tick();
                chk_reset("mid_rst");
                rst = 1'b1;
            end
            MOSI = mo[i];
            repeat (PH) tick();
            if (i == 1) chk("busy_mid", 32'(busy), 32'h1);
            mi[i] = MISO;
            SCLK  = 1'b1;
            if (i == 0) SPI_DATA_LEN = ~lc;
            repeat (PH) tick();
            SCLK = 1'b0;
        end
        repeat (PH) tick();
        if (stop_at >= n) chk("miso_hold", 32'(MISO), 32'h0);
        CS_N = 1'b1;
        repeat (PH) tick();
        chk("busy_end",   32'(busy), 32'h0);
        chk("miso_idle",  32'(MISO), 32'h0);
        chk("rx_q_empty", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic frame(input string nm, input logic [1:0] lc, input logic [31:0] mo,
                         input int stop_at, input int rst_at, input logic [31:0] exp_miso,
                         input int e_rxv, input int e_und, input int e_fe);
        int b_rxv, b_und, b_fe;
        logic [31:0] mi;
        b_rxv = n_rxv;
        b_und = n_und;
        b_fe  = n_fe;
        run_frame(lc, mo, stop_at, rst_at, mi);
        chk({nm, "_miso_word"}, mi, exp_miso);
        chk({nm, "_rx_valid_cnt"}, 32'(n_rxv - b_rxv), 32'(e_rxv));
        chk({nm, "_underrun_cnt"}, 32'(n_und - b_und), 32'(e_und));
        chk({nm, "_frame_err_cnt"}, 32'(n_fe - b_fe), 32'(e_fe));
    endtask

    initial begin
        rst = 1'b0; SCLK = 1'b0; CS_N = 1'b1; MOSI = 1'b0;
        tx_valid = 1'b0; tx_data = '0; SPI_DATA_LEN = 2'b00;
        @(negedge clk);
        repeat (3) tick();
        chk_reset("reset");
        rst = 1'b1;
        repeat (10) tick();

        push(32'h0000_00A5);
        frame("t1_len8", 2'b00, 32'h0000_003C, 99, 99, 32'h0000_00A5, 1, 0, 0);
        chk("t1_rx_literal", rx_data, 32'h0000_003C);

        push(32'hDEAD_BEEF);
        frame("t2_len32", 2'b11, 32'h1234_5678, 99, 99, 32'hDEAD_BEEF, 1, 0, 0);
        chk("t2_rx_literal", rx_data, 32'h1234_5678);

        frame("t3_underrun16", 2'b01, 32'hCAFE_BEEF, 99, 99, 32'h0, 1, 1, 0);
        chk("t3_rx_literal", rx_data, 32'h0000_BEEF);

        frame("t4_abort", 2'b00, 32'h0000_00FF, 5, 99, 32'h0, 0, 1, 1);
        chk("t4_rx_kept", rx_data, 32'h0000_BEEF);
        frame("t4_after", 2'b00, 32'h0000_0081, 99, 99, 32'h0, 1, 1, 0);
        chk("t4_rx_literal", rx_data, 32'h0000_0081);

        push(32'h0000_0011);
        chk("t5_ready_full", 32'(tx_ready), 32'h0);
        tx_data  = 32'h0000_0022;
        tx_valid = 1'b1;
        frame("t5_first", 2'b00, 32'h0000_005A, 99, 99, 32'h0000_0011, 1, 0, 0);
        chk("t5_ready_between", 32'(tx_ready), 32'h0);
        tx_valid = 1'b0;
        frame("t5_second", 2'b00, 32'h0000_00A5, 99, 99, 32'h0000_0022, 1, 0, 0);
        chk("t5_ready_after", 32'(tx_ready), 32'h1);

        push(32'hFF12_3456);
        frame("t6_len24", 2'b10, 32'h7765_4321, 99, 99, 32'h0012_3456, 1, 0, 0);
        chk("t6_rx_literal", rx_data, 32'h0065_4321);

        push(32'h0000_0033);
        frame("t7_reset", 2'b00, 32'h0000_00FF, 99, 3, 32'h0000_0003, 0, 0, 0);
        chk("t7_rx_cleared", rx_data, 32'h0);
        chk("t7_ready", 32'(tx_ready), 32'h1);
        frame("t7_after", 2'b00, 32'h0000_0096, 99, 99, 32'h0, 1, 1, 0);
        chk("t7_rx_literal", rx_data, 32'h0000_0096);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
